// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared widths and FSM state encoding for the register dump block
package reg_dump_pkg;

  localparam int DEF_N = 16;
  localparam int DEF_M = 4;
  localparam int DEF_O = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_READ = 3'd1;
  localparam state_t S_SEND = 3'd2;
  localparam state_t S_SUM  = 3'd3;
  localparam state_t S_DONE = 3'd4;

endpackage

// File: rtl/reg_dump_if.sv
// rtl/reg_dump_if.sv - dump output stream (data, address, last) with valid/ready
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) ();

  logic [N-1:0] outData;
  logic [M-1:0] outAddr;
  logic         outValid;
  logic         outReady;
  logic         outLast;

  modport master (output outData, outAddr, outValid, outLast, input outReady);
  modport slave  (input outData, outAddr, outValid, outLast, output outReady);

endinterface

// File: rtl/reg_dump_addr_ctr.sv
// rtl/reg_dump_addr_ctr.sv - modulo-O dump address counter with range load and last-address compare
module reg_dump_addr_ctr
  import reg_dump_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int O = DEF_O
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [M-1:0] loadFirst,
  input  logic [M-1:0] loadLast,
  output logic [M-1:0] cur,
  output logic         atLast
);

  localparam logic [M-1:0] TOP = M'(O - 1);

  logic [M-1:0] last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= '0;
      last <= '0;
    end else if (load) begin
      cur  <= loadFirst;
      last <= loadLast;
    end else if (inc) begin
      cur <= (cur == TOP) ? '0 : cur + M'(1);
    end
  end

  assign atLast = (cur == last);

endmodule

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - walks a register range through the regfile read port and streams each word out
// Optional trailing checksum word: define REG_DUMP_CHECKSUM_EN.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M,
  parameter int O = DEF_O
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   firstAddr,
  input  logic [M-1:0]   lastAddr,
  output logic [M-1:0]   rdAddr,
  input  logic [N-1:0]   rdData,
  reg_dump_if.master     dump,
  output logic           busy,
  output logic           done
);

  localparam logic [M:0] LIM = (M + 1)'(O);

  state_t       state, nxt;
  logic [M-1:0] cur;
  logic         atLast, accept, hs, ctrLoad, ctrInc;

  assign accept = start && ({1'b0, firstAddr} < LIM) && ({1'b0, lastAddr} < LIM);
  assign hs     = dump.outValid && dump.outReady;
  assign rdAddr = cur;

  reg_dump_addr_ctr #(.M(M), .O(O)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (ctrLoad),
    .inc       (ctrInc),
    .loadFirst (firstAddr),
    .loadLast  (lastAddr),
    .cur       (cur),
    .atLast    (atLast)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (accept) nxt = S_READ;
      S_READ: nxt = S_SEND;
      S_SEND: begin
        if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
          nxt = atLast ? S_SUM : S_READ;
`else
          nxt = atLast ? S_DONE : S_READ;
`endif
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_SUM:  if (hs) nxt = S_DONE;
`endif
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dump.outValid = (state == S_SEND) || (state == S_SUM);
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    ctrLoad       = (state == S_IDLE) && accept;
    ctrInc        = (state == S_SEND) && hs && !atLast;
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [N-1:0] sum;

  // Sum includes the word captured in READ, so it is complete by the last handshake.
  always_ff @(posedge clk) begin
    if (rst)                  sum <= '0;
    else if (ctrLoad)         sum <= '0;
    else if (state == S_READ) sum <= sum + rdData;
  end
`endif

  // Output word is a snapshot taken in READ and held through any backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump.outData <= '0;
      dump.outAddr <= '0;
      dump.outLast <= 1'b0;
    end else if (state == S_READ) begin
      dump.outData <= rdData;
      dump.outAddr <= cur;
`ifdef REG_DUMP_CHECKSUM_EN
      dump.outLast <= 1'b0;
`else
      dump.outLast <= atLast;
`endif
    end
`ifdef REG_DUMP_CHECKSUM_EN
    else if ((state == S_SEND) && hs && atLast) begin
      dump.outData <= sum;
      dump.outAddr <= '0;
      dump.outLast <= 1'b1;
    end
`endif
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential register-file reader for debug and scan-out. On a start pulse it walks an address range through the register file's combinational read port (`inr`/`outvalue`), snapshots each register, and emits one word per register on a valid/ready stream toward the debug/UART path. It is the read-side counterpart to the core's write port: it never writes, and it runs alongside normal register-file writes.

## Interface
- `N`, 16, register data width
- `M`, 4, register address width
- `O`, 16, number of registers (O ≤ 2^M)

Ports:
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin a dump
- `firstAddr`  in  M  first register to dump, latched on accepted `start`
- `lastAddr`  in  M  last register to dump, latched on accepted `start`
- `rdAddr`  out  M  address driven to the register file's `inr` port
- `rdData`  in  N  register file `outvalue` (combinational read of `rdAddr`)
- `outData`  out  N  dumped register value
- `outAddr`  out  M  address of `outData`
- `outValid`  out  1  stream word valid
- `outReady`  in  1  consumer accepts the word
- `outLast`  out  1  marks the final word of the dump
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of dump

## Operation
- States: IDLE, READ, SEND, SUM (checksum build only), DONE.
- IDLE: `start`=1 with `firstAddr`<O and `lastAddr`<O → latch range, cur=firstAddr, go to READ. `start` with either address ≥O is ignored and the block stays in IDLE.
- READ: `rdAddr`=cur; `outData`←`rdData`, `outAddr`←cur, `outLast`←(cur==last, non-checksum build); go to SEND.
- SEND: `outValid`=1. Hold until `outValid`&&`outReady`. On that handshake: cur==last → SUM if the checksum is compiled in, otherwise DONE. Else cur←(cur==O-1)?0:cur+1, go to READ.
- Range wraps: firstAddr>lastAddr dumps first..O-1, then 0..last. firstAddr==lastAddr dumps exactly one word.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` in any state other than IDLE is ignored.
- The snapshot is the register content during the READ cycle. A register-file write committing on the same edge is not included.
- `outData`, `outAddr` and `outLast` stay stable while `outValid`=1 and `outReady`=0.
- `rst` during any state: next state is IDLE and all outputs return to their reset values. No partial word is emitted after the reset.

## Timing
- Reset values: `rdAddr`=0, `outData`=0, `outAddr`=0, `outValid`=0, `outLast`=0, `busy`=0, `done`=0.
- `start` accepted at edge t → READ during cycle t+1 → `outValid`=1 from t+2.
- With `outReady` held high, throughput is 1 word per 2 cycles.
- `done` is asserted in the cycle after the final handshake.
- `busy`=1 from the cycle after the accepted `start` through the `done` cycle inclusive.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined:
  - A running sum of all dumped words is kept, modulo 2^N, and cleared on accepted `start`.
  - After the last register handshake, the SUM state emits one extra word: `outData`=sum, `outAddr`=0, `outLast`=1.
  - The last register word has `outLast`=0.
- Not defined: no SUM state and no accumulator. `outLast`=1 on the last register word.

## Structure
- Shared package:
  - state encoding localparams (IDLE/READ/SEND/SUM/DONE)
  - default widths N/M/O
- One natural sub-module, `reg_dump_addr_ctr`:
  - modulo-O address counter with load and increment
  - wrap at O-1
  - `atLast` compare output

## Test plan
Register file preloaded with rf[i]=16'h1000+i.
- Full dump: first=0, last=15, `outReady`=1 → 16 words 0x1000..0x100F at addresses 0..15. First `outValid` 2 cycles after `start`; `outLast` only on addr 15; `done` 1 cycle after the last handshake.
- Backpressure: first=3, last=5, `outReady` pattern 0,0,1 repeating → 3 words 0x1003..0x1005. Data, address and last stay stable during stalls; no word is duplicated or dropped.
- Wrap: first=14, last=1 → addresses 14,15,0,1 with data 0x100E,0x100F,0x1000,0x1001.
- Single word and invalid range:
  - first=last=7 → one word 0x1007 with `outLast`=1.
  - `start` with first=2, last=9 while busy → ignored, and the current dump completes unchanged.
- Reset mid-dump: assert `rst` after the 2nd handshake → `outValid`=0 and `busy`=0 next cycle. A new `start` with first=4, last=4 then yields a single word 0x1004.
- Checksum (`REG_DUMP_CHECKSUM_EN`): first=0, last=3 → words 0x1000..0x1003 with `outLast`=0, then word 0x4006 with `outAddr`=0 and `outLast`=1.
